ps2_mouse_decoder: RTL and testbench

Receive-only PS/2 mouse front end that produces the mouse signals the CPU register file latches: `data_ready`, `left_click`, `right_click`, `mouse_x` and `mouse_y`. It synchronizes the raw PS/2 clock and data lines and deframes 11-bit device-to-host frames. It assembles 3-byte stream-mode packets and accumulates an absolute, screen-clamped cursor position. Host-to-device commands, including stream enable 0xF4, are sent by a separate block.

---
 rtl/ps2_mouse_decoder.sv | 208 ++++++++++++++++++++
 tb/tb_ps2_mouse_decoder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_decoder.sv
// ps2_mouse_decoder
// Receive-only PS/2 mouse front end. It synchronizes the raw PS/2 lines and
// deframes 11-bit device-to-host frames. It assembles 3-byte stream-mode
// packets and keeps an absolute cursor position clamped to the screen.
//
// Optional feature macro: MOUSE_PARITY_CHECK_EN
//   defined   - a frame whose data bits plus parity bit are not odd is rejected
//   undefined - the parity bit is consumed and ignored
//
// Output semantics: data_ready is a one-cycle strobe. When it is high,
// mouse_x/mouse_y/left_click/right_click already hold the new packet's
// values. Those values stay stable until the next strobe. There is no
// back-pressure: the consumer must latch the outputs on the strobe.
// The frame FSM state is visible on the internal signal frame_state.
module ps2_mouse_decoder #(
   parameter int SCREEN_W       = 640,
   parameter int SCREEN_H       = 480,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic        data_ready,
   output logic        left_click,
   output logic        right_click,
   output logic [15:0] mouse_x,
   output logic [15:0] mouse_y,
   output logic        frame_error
);

   localparam int              TW           = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0]   TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic signed [17:0] X_MAX     = 18'(SCREEN_W - 1);
   localparam logic signed [17:0] Y_MAX     = 18'(SCREEN_H - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } frame_state_t;

   frame_state_t frame_state;

   // Synchronizer and edge-detect registers
   logic ps2_clk_s1, ps2_clk_s2, ps2_clk_prev;
   logic ps2_data_s1, ps2_data_s2;
   logic ps2_fall;

   // Frame and packet state
   logic [7:0]    shift_reg;
   logic [2:0]    bit_cnt;
   logic          parity_good;
   logic [1:0]    byte_idx;
   logic          b0_left, b0_right, b0_xsign, b0_ysign, b0_xovf, b0_yovf;
   logic [7:0]    byte1;
   logic [TW-1:0] to_cnt;
   logic          packet_active;
   logic          parity_now;

   // Position update datapath
   logic signed [17:0] dx, dy, x_sum, y_sum;
   logic [15:0]        x_next, y_next;

   // Two-flop synchronizers plus one edge-detect stage; lines idle high
   always_ff @(posedge clk) begin
      if (rst) begin
         ps2_clk_s1   <= 1'b1;
         ps2_clk_s2   <= 1'b1;
         ps2_clk_prev <= 1'b1;
         ps2_data_s1  <= 1'b1;
         ps2_data_s2  <= 1'b1;
      end else begin
         ps2_clk_s1   <= ps2_clk;
         ps2_clk_s2   <= ps2_clk_s1;
         ps2_clk_prev <= ps2_clk_s2;
         ps2_data_s1  <= ps2_data;
         ps2_data_s2  <= ps2_data_s1;
      end
   end

   assign ps2_fall      = ps2_clk_prev & ~ps2_clk_s2;
   assign packet_active = (frame_state != ST_IDLE) || (byte_idx != 2'd0);

`ifdef MOUSE_PARITY_CHECK_EN
   // Odd parity over the eight data bits and the incoming parity bit
   assign parity_now = ^{shift_reg, ps2_data_s2};
`else
   // The parity bit is consumed but never rejects a frame
   assign parity_now = 1'b1;
`endif

   // Next cursor position from the buffered deltas, clamped to the screen
   always_comb begin
      dx     = b0_xovf ? 18'sd0 : {{10{b0_xsign}}, byte1};
      dy     = b0_yovf ? 18'sd0 : {{10{b0_ysign}}, shift_reg};
      x_sum  = $signed({2'b00, mouse_x}) + dx;
      y_sum  = $signed({2'b00, mouse_y}) - dy;
      x_next = x_sum[15:0];
      y_next = y_sum[15:0];
      if (x_sum < 18'sd0)
         x_next = 16'd0;
      else if (x_sum > X_MAX)
         x_next = 16'(SCREEN_W - 1);
      if (y_sum < 18'sd0)
         y_next = 16'd0;
      else if (y_sum > Y_MAX)
         y_next = 16'(SCREEN_H - 1);
   end

   // Frame FSM, packet assembly, timeout and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_state <= ST_IDLE;
         shift_reg   <= 8'd0;
         bit_cnt     <= 3'd0;
         parity_good <= 1'b0;
         byte_idx    <= 2'd0;
         b0_left     <= 1'b0;
         b0_right    <= 1'b0;
         b0_xsign    <= 1'b0;
         b0_ysign    <= 1'b0;
         b0_xovf     <= 1'b0;
         b0_yovf     <= 1'b0;
         byte1       <= 8'd0;
         to_cnt      <= '0;
         data_ready  <= 1'b0;
         frame_error <= 1'b0;
         left_click  <= 1'b0;
         right_click <= 1'b0;
         mouse_x     <= 16'(SCREEN_W / 2);
         mouse_y     <= 16'(SCREEN_H / 2);
      end else begin
         data_ready  <= 1'b0;
         frame_error <= 1'b0;
         if (ps2_fall) begin
            // Any edge restarts the idle count, even in a cycle that would time out
            to_cnt <= '0;
            case (frame_state)
               ST_IDLE: begin
                  if (!ps2_data_s2) begin
                     frame_state <= ST_DATA;
                     bit_cnt     <= 3'd0;
                  end
               end
               ST_DATA: begin
                  shift_reg <= {ps2_data_s2, shift_reg[7:1]};
                  bit_cnt   <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7)
                     frame_state <= ST_PARITY;
               end
               ST_PARITY: begin
                  parity_good <= parity_now;
                  frame_state <= ST_STOP;
               end
               ST_STOP: begin
                  frame_state <= ST_IDLE;
                  if (!ps2_data_s2 || !parity_good) begin
                     frame_error <= 1'b1;
                     byte_idx    <= 2'd0;
                  end else begin
                     case (byte_idx)
                        2'd0: begin
                           // Bytes without the sync bit cannot start a packet
                           if (shift_reg[3]) begin
                              b0_left  <= shift_reg[0];
                              b0_right <= shift_reg[1];
                              b0_xsign <= shift_reg[4];
                              b0_ysign <= shift_reg[5];
                              b0_xovf  <= shift_reg[6];
                              b0_yovf  <= shift_reg[7];
                              byte_idx <= 2'd1;
                           end
                        end
                        2'd1: begin
                           byte1    <= shift_reg;
                           byte_idx <= 2'd2;
                        end
                        default: begin
                           mouse_x     <= x_next;
                           mouse_y     <= y_next;
                           left_click  <= b0_left;
                           right_click <= b0_right;
                           data_ready  <= 1'b1;
                           byte_idx    <= 2'd0;
                        end
                     endcase
                  end
               end
               default: frame_state <= ST_IDLE;
            endcase
         end else if (packet_active) begin
            if (to_cnt == TIMEOUT_LAST) begin
               to_cnt      <= '0;
               frame_state <= ST_IDLE;
               byte_idx    <= 2'd0;
               frame_error <= 1'b1;
            end else begin
               to_cnt <= to_cnt + TW'(1);
            end
         end else begin
            to_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_ps2_mouse_decoder.sv
// Testbench for ps2_mouse_decoder: directed scenarios plus randomized packets
// checked against a packet-level reference model with a scoreboard queue.
module tb_ps2_mouse_decoder;

   localparam int W    = 640;
   localparam int H    = 480;
   localparam int TO   = 2000;
   localparam int HALF = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic        data_ready, left_click, right_click, frame_error;
   logic [15:0] mouse_x, mouse_y;

   int checks = 0;
   int errors = 0;
   int dr_seen = 0;
   int fe_seen = 0;
   int exp_dr = 0;
   int exp_fe = 0;

   // Scoreboard entries: {left, right, x[15:0], y[15:0]}
   logic [33:0] exp_q[$];

   // Reference model state
   int         m_idx, m_x, m_y;
   logic [7:0] m_b0, m_b1;

   ps2_mouse_decoder #(
      .SCREEN_W(W), .SCREEN_H(H), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .data_ready(data_ready), .left_click(left_click), .right_click(right_click),
      .mouse_x(mouse_x), .mouse_y(mouse_y), .frame_error(frame_error)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Monitor: sample away from the active edge and score each data_ready
   always @(negedge clk) begin
      logic [33:0] e;
      if (!rst) begin
         if (frame_error) fe_seen++;
         if (data_ready) begin
            dr_seen++;
            check("fe_with_dr", frame_error, 0);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("left", left_click, e[33]);
               check("right", right_click, e[32]);
               check("x", mouse_x, e[31:16]);
               check("y", mouse_y, e[15:0]);
            end
         end
      end
   end

   function automatic int clamp(input int v, input int hi);
      if (v < 0) return 0;
      if (v > hi) return hi;
      return v;
   endfunction

   // Reference model: one received byte, with the frame outcome known up front
   task automatic model_byte(input logic [7:0] b, input bit frame_ok);
      int dx, dy;
      if (!frame_ok) begin
         m_idx = 0;
         exp_fe++;
         return;
      end
      case (m_idx)
         0: if (b[3]) begin m_b0 = b; m_idx = 1; end
         1: begin m_b1 = b; m_idx = 2; end
         default: begin
            dx = m_b0[6] ? 0 : (m_b0[4] ? int'(m_b1) - 256 : int'(m_b1));
            dy = m_b0[7] ? 0 : (m_b0[5] ? int'(b) - 256 : int'(b));
            m_x = clamp(m_x + dx, W - 1);
            m_y = clamp(m_y - dy, H - 1);
            exp_q.push_back({m_b0[0], m_b0[1], 16'(m_x), 16'(m_y)});
            exp_dr++;
            m_idx = 0;
         end
      endcase
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      ps2_clk = 1'b1;
      ps2_data = 1'b1;
      wait_cycles(2);
      rst = 1'b0;
      m_idx = 0; m_x = W / 2; m_y = H / 2;
      exp_q.delete();
      dr_seen = 0; fe_seen = 0; exp_dr = 0; exp_fe = 0;
   endtask

   // Drive one 11-bit device-to-host frame, LSB first
   task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit bad_stop);
      logic [10:0] bits;
      bits = {~bad_stop, (~^b) ^ flip_par, b, 1'b0};
      for (int i = 0; i < 11; i++) begin
         ps2_data = bits[i];
         wait_cycles(HALF);
         ps2_clk = 1'b0;
         wait_cycles(HALF);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      wait_cycles(3 * HALF);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit flip_par, input bit bad_stop);
      bit ok;
      ok = !bad_stop;
`ifdef MOUSE_PARITY_CHECK_EN
      if (flip_par) ok = 1'b0;
`endif
      model_byte(b, ok);
      send_frame(b, flip_par, bad_stop);
   endtask

   task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      send_byte(b0, 0, 0);
      send_byte(b1, 0, 0);
      send_byte(b2, 0, 0);
   endtask

   task automatic phase_end(input string tag);
      check({tag, "_dr_count"}, dr_seen, exp_dr);
      check({tag, "_fe_count"}, fe_seen, exp_fe);
      check({tag, "_queue_left"}, exp_q.size(), 0);
   endtask

   initial begin
      logic [7:0] r0, r1, r2;

      // Reset state and quiet idle lines
      do_reset();
      check("rst_x", mouse_x, 320);
      check("rst_y", mouse_y, 240);
      check("rst_left", left_click, 0);
      check("rst_right", right_click, 0);
      check("rst_dr", data_ready, 0);
      check("rst_fe", frame_error, 0);
      wait_cycles(100);
      phase_end("idle");

      // Left click, small move
      send_packet(8'h09, 8'h05, 8'h03);
      check("tp1_x", mouse_x, 325);
      check("tp1_y", mouse_y, 237);
      check("tp1_left", left_click, 1);
      check("tp1_right", right_click, 0);
      phase_end("tp1");

      // Negative deltas, right button
      do_reset();
      send_packet(8'h3A, 8'hF6, 8'hFB);
      check("tp2_x", mouse_x, 310);
      check("tp2_y", mouse_y, 245);
      check("tp2_right", right_click, 1);
      phase_end("tp2");

      // Right-edge clamp, then X overflow ignored
      do_reset();
      send_packet(8'h08, 8'h7F, 8'h00);
      check("tp3_x1", mouse_x, 447);
      send_packet(8'h08, 8'h7F, 8'h00);
      check("tp3_x2", mouse_x, 574);
      send_packet(8'h08, 8'h7F, 8'h00);
      check("tp3_x3", mouse_x, 639);
      check("tp3_y", mouse_y, 240);
      send_packet(8'h48, 8'h10, 8'h00);
      check("tp3_ovf_x", mouse_x, 639);
      phase_end("tp3");

      // Corrupted parity on byte 1, then a clean packet
      do_reset();
      send_byte(8'h09, 0, 0);
      send_byte(8'h01, 1, 0);
      send_byte(8'h00, 0, 0);
      send_packet(8'h09, 8'h01, 8'h00);
`ifdef MOUSE_PARITY_CHECK_EN
      check("par_x", mouse_x, 321);
`else
      check("par_x", mouse_x, 322);
`endif
      phase_end("parity");

      // Bad stop bit mid-packet restarts assembly
      do_reset();
      send_byte(8'h09, 0, 0);
      send_byte(8'h05, 0, 1);
      send_packet(8'h09, 8'h02, 8'h00);
      check("stop_x", mouse_x, 322);
      phase_end("stop");

      // Non-sync leading byte, stall into timeout, then a full packet
      do_reset();
      send_byte(8'h00, 0, 0);
      send_byte(8'h09, 0, 0);
      wait_cycles(TO + 100);
      m_idx = 0;
      exp_fe++;
      check("to_fe_count", fe_seen, exp_fe);
      send_packet(8'h09, 8'h02, 8'h00);
      check("to_x", mouse_x, 322);
      phase_end("timeout");

      // Reset in the middle of a frame discards it
      do_reset();
      send_byte(8'h09, 0, 0);
      for (int i = 0; i < 5; i++) begin
         ps2_data = (i == 0) ? 1'b0 : 1'(i & 1);
         wait_cycles(HALF);
         ps2_clk = 1'b0;
         wait_cycles(HALF);
         ps2_clk = 1'b1;
      end
      do_reset();
      send_packet(8'h09, 8'h01, 8'h00);
      check("midrst_x", mouse_x, 321);
      phase_end("midrst");

      // Randomized packets with occasional junk and broken frames
      do_reset();
      for (int p = 0; p < 25; p++) begin
         if ($urandom_range(0, 4) == 0)
            send_byte(8'($urandom_range(0, 255)) & 8'hF7, 0, 0);
         if ($urandom_range(0, 7) == 0)
            send_byte(8'($urandom_range(0, 255)), 0, 1);
         r0 = 8'($urandom_range(0, 255)) | 8'h08;
         if ($urandom_range(0, 7) != 0) r0[6] = 1'b0;
         if ($urandom_range(0, 7) != 0) r0[7] = 1'b0;
         r1 = 8'($urandom_range(0, 255));
         r2 = 8'($urandom_range(0, 255));
         send_packet(r0, r1, r2);
      end
      check("rand_final_x", mouse_x, 16'(m_x));
      check("rand_final_y", mouse_y, 16'(m_y));
      phase_end("rand");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
